// File: rtl/action_pkg.sv
// action_pkg: channel FSM states, action indices, counter width and a lowest-set-bit helper
package action_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_CONFIRM, ST_FIRE, ST_COOLDOWN} state_e;
    localparam int ACT_PUNCH = 0;
    localparam int ACT_KICK  = 1;
    localparam int COUNT_W   = 8;
    function automatic logic [3:0] lowest_idx(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (v[i]) idx = 4'(i);
        return idx;
    endfunction
endpackage

// File: rtl/action_event_filter_if.sv
// action_event_filter_if: filter bus; master drives frame_tick/enable/clear_counts/raw_act, slave drives act_pulse/cooling/act_count
interface action_event_filter_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_ACTIONS = 2
);
    import action_pkg::*;
    logic                               frame_tick;
    logic                               enable;
    logic                               clear_counts;
    logic [NUM_PLAYERS*NUM_ACTIONS-1:0] raw_act;
    logic [NUM_PLAYERS*NUM_ACTIONS-1:0] act_pulse;
    logic [NUM_PLAYERS-1:0]             cooling;
    logic [NUM_PLAYERS*COUNT_W-1:0]     act_count;
    modport master (
        output frame_tick, enable, clear_counts, raw_act,
        input  act_pulse, cooling, act_count
    );
    modport slave (
        input  frame_tick, enable, clear_counts, raw_act,
        output act_pulse, cooling, act_count
    );
endinterface

// File: rtl/action_channel_fsm.sv
// action_channel_fsm: one player's debounce/cooldown FSM; in: clk_65mhz, reset, frame_tick, enable, clear_counts, raw_act; out: act_pulse, cooling, act_count
module action_channel_fsm
    import action_pkg::*;
#(
    parameter int NUM_ACTIONS     = 2,
    parameter int CONFIRM_FRAMES  = 3,
    parameter int COOLDOWN_FRAMES = 15
) (
    input  logic                   clk_65mhz,
    input  logic                   reset,
    input  logic                   frame_tick,
    input  logic                   enable,
    input  logic                   clear_counts,
    input  logic [NUM_ACTIONS-1:0] raw_act,
    output logic [NUM_ACTIONS-1:0] act_pulse,
    output logic                   cooling,
    output logic [COUNT_W-1:0]     act_count
);
    state_e                 state_q, state_d;
    logic [3:0]             cand_q, cand_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [NUM_ACTIONS-1:0] pulse_q, pulse_d;
    logic                   cool_q, cool_d;
    logic [COUNT_W-1:0]     count_q, count_d;
    logic [15:0]            raw_w;
    assign raw_w = 16'(raw_act);
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        if (!enable) begin
            state_d = ST_IDLE;
            cand_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (frame_tick && |raw_act) begin
                    cand_d  = lowest_idx(raw_w);
                    cnt_d   = 8'd1;
                    state_d = CONFIRM_FRAMES == 1 ? ST_FIRE : ST_CONFIRM;
                end
                ST_CONFIRM: if (frame_tick) begin
                    cnt_d   = raw_w[cand_q] ? cnt_q + 8'd1 : 8'd0;
                    state_d = !raw_w[cand_q] ? ST_IDLE :
                              cnt_d == 8'(CONFIRM_FRAMES) ? ST_FIRE : ST_CONFIRM;
                end
                ST_FIRE: begin
                    cnt_d   = '0;
                    state_d = COOLDOWN_FRAMES == 0 ? ST_IDLE : ST_COOLDOWN;
                end
                default: if (frame_tick) begin
                    cnt_d   = cnt_q + 8'd1 == 8'(COOLDOWN_FRAMES) ? 8'd0 : cnt_q + 8'd1;
                    state_d = cnt_q + 8'd1 == 8'(COOLDOWN_FRAMES) ? ST_IDLE : ST_COOLDOWN;
                end
            endcase
        end
        // outputs are registered: decode them from the state being entered
        pulse_d = state_d == ST_FIRE ? NUM_ACTIONS'(16'd1 << cand_d) : '0;
        cool_d  = state_d == ST_COOLDOWN;
        count_d = clear_counts ? '0 :
                  (state_d == ST_FIRE && count_q != '1) ? count_q + COUNT_W'(1) : count_q;
    end
    always_ff @(posedge clk_65mhz) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            pulse_q <= '0;
            cool_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            cool_q  <= cool_d;
            count_q <= count_d;
        end
    end
    assign act_pulse = pulse_q;
    assign cooling   = cool_q;
    assign act_count = count_q;
endmodule

// File: rtl/action_event_filter.sv
// action_event_filter: per-player action debounce/cooldown filter; ports: clk_65mhz, reset, bus (action_event_filter_if.slave)
module action_event_filter
    import action_pkg::*;
#(
    parameter int NUM_PLAYERS     = 2,
    parameter int NUM_ACTIONS     = 2,
    parameter int CONFIRM_FRAMES  = 3,
    parameter int COOLDOWN_FRAMES = 15
) (
    input logic                  clk_65mhz,
    input logic                  reset,
    action_event_filter_if.slave bus
);
    logic [NUM_PLAYERS*NUM_ACTIONS-1:0] pulse_w;
    logic [NUM_PLAYERS-1:0]             cool_w;
    logic [NUM_PLAYERS*COUNT_W-1:0]     count_w;
    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_ch
        action_channel_fsm #(
            .NUM_ACTIONS     (NUM_ACTIONS),
            .CONFIRM_FRAMES  (CONFIRM_FRAMES),
            .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
        ) u_ch (
            .clk_65mhz    (clk_65mhz),
            .reset        (reset),
            .frame_tick   (bus.frame_tick),
            .enable       (bus.enable),
            .clear_counts (bus.clear_counts),
            .raw_act      (bus.raw_act[p*NUM_ACTIONS +: NUM_ACTIONS]),
            .act_pulse    (pulse_w[p*NUM_ACTIONS +: NUM_ACTIONS]),
            .cooling      (cool_w[p]),
            .act_count    (count_w[p*COUNT_W +: COUNT_W])
        );
    end
    assign bus.act_pulse = pulse_w;
    assign bus.cooling   = cool_w;
    assign bus.act_count = count_w;
endmodule

// File: tb/tb_action_event_filter.sv
// tb_action_event_filter: table, directed and random checks of action_event_filter against a frame-level model
module tb_action_event_filter;
    import action_pkg::*;
    localparam int NP = 2;
    localparam int NA = 2;
    localparam int CF = 3;
    localparam int CD = 15;
    logic clk = 1'b0;
    logic rst1, rst2;
    always #5 clk = ~clk;
    action_event_filter_if #(.NUM_PLAYERS(NP), .NUM_ACTIONS(NA)) bus1();
    action_event_filter_if #(.NUM_PLAYERS(NP), .NUM_ACTIONS(NA)) bus2();
    action_event_filter #(.NUM_PLAYERS(NP), .NUM_ACTIONS(NA), .CONFIRM_FRAMES(CF), .COOLDOWN_FRAMES(CD)) dut1 (
        .clk_65mhz(clk), .reset(rst1), .bus(bus1.slave));
    action_event_filter #(.NUM_PLAYERS(NP), .NUM_ACTIONS(NA), .CONFIRM_FRAMES(1), .COOLDOWN_FRAMES(0)) dut2 (
        .clk_65mhz(clk), .reset(rst2), .bus(bus2.slave));
    int n_checks = 0;
    int n_fail = 0;
    int m_cand[NP];
    int m_run[NP];
    int m_cool[NP];
    int m_cnt[NP];
    bit m_pend[NP];
    typedef struct {
        logic       rst, tick, en, clr;
        logic [3:0] raw;
        logic [3:0] e_pulse;
        logic [1:0] e_cool;
        logic [7:0] e_cnt0;
    } vec_t;
    vec_t tbl[22];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic drive(input logic r, input logic t, input logic e, input logic c, input logic [3:0] raw);
        rst1 = r;
        bus1.frame_tick = t;
        bus1.enable = e;
        bus1.clear_counts = c;
        bus1.raw_act = raw;
    endtask
    // frame-level reference: a streak of identical high samples of one candidate, then a fixed cooldown
    task automatic model_step();
        for (int p = 0; p < NP; p++) begin
            logic [NA-1:0] bits;
            bits = bus1.raw_act[p*NA +: NA];
            if (rst1) begin
                m_cand[p] = -1; m_run[p] = 0; m_cool[p] = 0; m_pend[p] = 0; m_cnt[p] = 0;
            end else begin
                if (!bus1.enable) begin
                    m_cand[p] = -1; m_run[p] = 0; m_cool[p] = 0; m_pend[p] = 0;
                end else if (m_pend[p]) begin
                    m_pend[p] = 0; m_cand[p] = -1; m_cool[p] = CD;
                end else if (m_cool[p] > 0) begin
                    if (bus1.frame_tick) m_cool[p]--;
                end else if (bus1.frame_tick) begin
                    if (m_cand[p] < 0) begin
                        for (int a = NA - 1; a >= 0; a--)
                            if (bits[a]) begin m_cand[p] = a; m_run[p] = 1; end
                    end else if (bits[m_cand[p]]) m_run[p]++;
                    else begin m_cand[p] = -1; m_run[p] = 0; end
                    if (m_cand[p] >= 0 && m_run[p] == CF) begin
                        m_pend[p] = 1; m_run[p] = 0;
                        m_cnt[p] = m_cnt[p] < 255 ? m_cnt[p] + 1 : 255;
                    end
                end
                if (bus1.clear_counts) m_cnt[p] = 0;
            end
        end
    endtask
    function automatic logic [3:0] exp_pulse();
        logic [3:0] e;
        e = '0;
        for (int p = 0; p < NP; p++)
            if (m_pend[p]) e[p*NA + m_cand[p]] = 1'b1;
        return e;
    endfunction
    function automatic logic [1:0] exp_cool();
        logic [1:0] e;
        for (int p = 0; p < NP; p++) e[p] = m_cool[p] > 0;
        return e;
    endfunction
    function automatic logic [15:0] exp_cnt();
        logic [15:0] e;
        for (int p = 0; p < NP; p++) e[p*8 +: 8] = 8'(m_cnt[p]);
        return e;
    endfunction
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_pulse", 32'(bus1.act_pulse), 32'(exp_pulse()));
        check("model_cooling", 32'(bus1.cooling), 32'(exp_cool()));
        check("model_count", 32'(bus1.act_count), 32'(exp_cnt()));
    endtask
    task automatic ticks(input int n, input logic [3:0] raw);
        drive(1'b0, 1'b1, 1'b1, 1'b0, raw);
        repeat (n) step();
    endtask
    initial begin
        logic [3:0] seen;
        logic [3:0] seq6[6];
        logic [3:0] raw_r;
        int pulses;
        logic cool_seen;
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 2'b00, 8'd0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 4'h0, 2'b00, 8'd0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 4'h0, 2'b00, 8'd0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 4'h0, 2'b00, 8'd0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 4'h1, 2'b00, 8'd1};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 4'h0, 2'b01, 8'd1};
        for (int i = 6; i < 20; i++) tbl[i] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 4'h0, 2'b01, 8'd1};
        tbl[20] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 4'h0, 2'b00, 8'd1};
        tbl[21] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 2'b00, 8'd1};
        rst2 = 1'b1;
        bus2.frame_tick = 1'b0; bus2.enable = 1'b1; bus2.clear_counts = 1'b0; bus2.raw_act = '0;
        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].rst, tbl[i].tick, tbl[i].en, tbl[i].clr, tbl[i].raw);
            step();
            check($sformatf("tbl%0d_pulse", i), 32'(bus1.act_pulse), 32'(tbl[i].e_pulse));
            check($sformatf("tbl%0d_cooling", i), 32'(bus1.cooling), 32'(tbl[i].e_cool));
            check($sformatf("tbl%0d_count0", i), 32'(bus1.act_count[7:0]), 32'(tbl[i].e_cnt0));
        end
        // broken streak restarts confirmation
        seq6 = '{4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1};
        seen = '0;
        for (int k = 0; k < 6; k++) begin
            ticks(1, seq6[k]);
            if (k < 5) seen |= bus1.act_pulse;
        end
        check("broken_no_early", 32'(seen), 32'h0);
        check("broken_fire", 32'(bus1.act_pulse), 32'h1);
        check("broken_count", 32'(bus1.act_count[7:0]), 32'd2);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        step();
        check("fire_one_cycle", 32'(bus1.act_pulse), 32'h0);
        check("cooling_after_fire", 32'(bus1.cooling), 32'h1);
        ticks(15, 4'h0);
        check("cooldown_release", 32'(bus1.cooling), 32'h0);
        // clear, then both players confirm together
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
        step();
        check("clear_counts", 32'(bus1.act_count), 32'h0);
        ticks(3, 4'h5);
        check("dual_fire", 32'(bus1.act_pulse), 32'h5);
        check("dual_counts", 32'(bus1.act_count), 32'h0101);
        ticks(16, 4'h0);
        check("dual_release", 32'(bus1.cooling), 32'h0);
        // reset mid-confirm
        ticks(2, 4'h1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h1);
        step();
        check("reset_count", 32'(bus1.act_count), 32'h0);
        check("reset_pulse", 32'(bus1.act_pulse), 32'h0);
        seen = '0;
        for (int k = 0; k < 2; k++) begin
            ticks(1, 4'h1);
            seen |= bus1.act_pulse;
        end
        check("reset_no_early", 32'(seen), 32'h0);
        ticks(1, 4'h1);
        check("reset_then_fire", 32'(bus1.act_pulse), 32'h1);
        // enable drop mid-cooldown
        ticks(4, 4'h0);
        check("cooling_before_disable", 32'(bus1.cooling), 32'h1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        step();
        check("disable_cooling", 32'(bus1.cooling), 32'h0);
        check("disable_count_kept", 32'(bus1.act_count[7:0]), 32'd1);
        // clear coincident with the fire
        ticks(2, 4'h1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h1);
        step();
        check("clear_wins_pulse", 32'(bus1.act_pulse), 32'h1);
        check("clear_wins_count", 32'(bus1.act_count[7:0]), 32'd0);
        ticks(16, 4'h0);
        // random traffic against the model
        raw_r = '0;
        for (int k = 0; k < 3000; k++) begin
            raw_r = raw_r ^ (4'($urandom) & 4'($urandom));
            drive($urandom_range(0, 299) == 0, 1'($urandom), $urandom_range(0, 39) != 0,
                  $urandom_range(0, 59) == 0, raw_r);
            step();
        end
        // saturation on the single-frame, no-cooldown instance
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        rst2 = 1'b0;
        bus2.frame_tick = 1'b1;
        bus2.raw_act = 4'h1;
        pulses = 0;
        cool_seen = 1'b0;
        for (int k = 0; k < 520; k++) begin
            step();
            if (bus2.act_pulse[ACT_PUNCH]) pulses++;
            cool_seen |= |bus2.cooling;
        end
        check("sat_pulses", 32'(pulses), 32'd260);
        check("sat_count", 32'(bus2.act_count), 32'h00FF);
        check("sat_no_cooling", 32'(cool_seen), 32'h0);
        bus2.frame_tick = 1'b0;
        bus2.raw_act = 4'h0;
        bus2.clear_counts = 1'b1;
        step();
        check("sat_clear", 32'(bus2.act_count), 32'h0);
        bus2.clear_counts = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/action_event_filter.md
ACTION_EVENT_FILTER -- requirements
Module: action_event_filter

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of independent player channels.
REQ-002 Parameter NUM_ACTIONS, default 2, actions per player (index 0 = punch, 1 = kick).
REQ-003 Parameter CONFIRM_FRAMES, default 3, consecutive sampled frames needed to accept an action (legal 1..15).
REQ-004 Parameter COOLDOWN_FRAMES, default 15, frames after an accepted action during which that player is ignored (legal 0..255).
REQ-005 clk_65mhz  input  1  system clock; one clock domain; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 frame_tick  input  1  one-cycle strobe per video frame; the only cycle on which raw_act is sampled.
REQ-008 enable  input  1  high = filtering active; low = all channels held idle.
REQ-009 clear_counts  input  1  one-cycle request to zero all action counters.
REQ-010 raw_act  input  NUM_PLAYERS*NUM_ACTIONS  raw detector levels; bit p*NUM_ACTIONS+a = player p, action a.
REQ-011 act_pulse  output  NUM_PLAYERS*NUM_ACTIONS  one-cycle accepted-action pulse, same bit mapping, at most one bit per player.
REQ-012 cooling  output  NUM_PLAYERS  high while player p is in COOLDOWN.
REQ-013 act_count  output  NUM_PLAYERS*8  per-player saturating count of accepted actions.

Function
REQ-014 Each player channel SHALL run an independent FSM with states IDLE, CONFIRM, FIRE, COOLDOWN, a 4-bit candidate-action register and an 8-bit frame counter.
REQ-015 IDLE: on frame_tick with any of the player's raw bits high, latch the lowest set index as candidate, counter=1, go CONFIRM (or FIRE directly if CONFIRM_FRAMES==1); otherwise stay.
REQ-016 CONFIRM: on frame_tick with raw[candidate] high, counter increments; on reaching CONFIRM_FRAMES go FIRE.
REQ-017 CONFIRM: on frame_tick with raw[candidate] low, go IDLE with counter=0; no new candidate is latched on that same tick.
REQ-018 Changes to non-candidate raw bits SHALL NOT affect CONFIRM.
REQ-019 FIRE SHALL last exactly one clock: act_pulse[candidate] high, act_count increments saturating at 255, then COOLDOWN with counter=0 (IDLE if COOLDOWN_FRAMES==0).
REQ-020 Latency: act_pulse asserts in the cycle immediately after the frame_tick that supplied the CONFIRM_FRAMES-th consecutive high sample.
REQ-021 COOLDOWN: counter increments per frame_tick; on reaching COOLDOWN_FRAMES go IDLE; raw_act ignored throughout; cooling=1.
REQ-022 frame_tick and raw_act SHALL NOT be sampled in FIRE; a frame_tick coinciding with FIRE is counted by neither CONFIRM nor COOLDOWN.
REQ-023 enable low SHALL force every channel to IDLE on the next edge, suppress act_pulse in that cycle and after, and retain act_count.
REQ-024 clear_counts SHALL zero every act_count on the next edge; if coincident with FIRE, the result is 0 (clear wins).
REQ-025 Players SHALL be fully independent; simultaneous FIRE on several players is legal.

Reset
REQ-026 On reset: all channels IDLE, counters and candidates 0, act_pulse=0, cooling=0, act_count=0, on the following edge.
REQ-027 Reset SHALL override enable, clear_counts and frame_tick, including mid-CONFIRM and mid-COOLDOWN.

Structure
REQ-028 Package action_pkg SHALL hold the FSM state enum and constants ACT_PUNCH=0, ACT_KICK=1, COUNT_W=8.
REQ-029 One sub-module, action_channel_fsm (one player: FSM, counter, candidate, act_count), SHALL be instantiated NUM_PLAYERS times by a generate loop.
REQ-030 All outputs SHALL be registered.

Verification
REQ-031 Defaults; raw_act=4'b0001 held for 3 frame_ticks -> act_pulse=4'b0001 for exactly one cycle after the third tick, cooling[0]=1, act_count[7:0]=1.
REQ-032 raw_act=4'b0011 on the same ticks -> only bit 0 (punch) pulses; kick ignored; cooldown releases after 15 further ticks, cooling[0]=0.
REQ-033 raw bit 0 high for 2 ticks, low on 3rd, high for 3 more -> single pulse after the 6th tick, none earlier.
REQ-034 Player 0 and player 1 both confirm on the same tick -> act_pulse=4'b0101 in one cycle; both counters=1.
REQ-035 Reset asserted mid-CONFIRM after 2 ticks, then raw held -> no pulse until 3 ticks after reset release; enable dropped mid-COOLDOWN -> cooling=0 next cycle, act_count retained.
REQ-036 Fire player 0 260 times with COOLDOWN_FRAMES=0 -> act_count saturates at 255; clear_counts pulse -> 0 next cycle.
